// File: rtl/bit_unpack.sv
// bit_unpack: LSB-first serial-to-parallel unpacker with an IDLE/FILL/HOLD pop/present handshake.
// Define BIT_UNPACK_CNT_EN to add field_cnt; the serial input is named bit_val because "bit" is a keyword.
module bit_unpack #(
    parameter int FIELD_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enb,
    input  logic               bit_val,
    input  logic               rempty_in,
    output logic               rinc_out,
    output logic [FIELD_W-1:0] field,
    output logic               rempty_out,
    input  logic               rinc_in
`ifdef BIT_UNPACK_CNT_EN
    ,
    output logic [15:0]        field_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [4:0] LAST = 5'(FIELD_W - 1);

    state_t     state;
    state_t     next_state;
    logic [4:0] cnt;
    logic       pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Pops only happen in FILL, so the HOLD cycle is the single bubble between fields.
    always_comb begin
        next_state = state;
        rinc_out   = 1'b0;
        rempty_out = 1'b1;
        case (state)
            IDLE: begin
                if (enb) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                rinc_out = ~rempty_in;
                if (!rempty_in && (cnt == LAST)) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                rempty_out = 1'b0;
                if (rinc_in) begin
                    next_state = enb ? FILL : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign pop = rinc_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            field <= '0;
        end else if (pop) begin
            for (int i = 0; i < FIELD_W; i++) begin
                if (cnt == 5'(i)) begin
                    field[i] <= bit_val;
                end
            end
            cnt <= (cnt == LAST) ? 5'd0 : cnt + 5'd1;
        end
    end

`ifdef BIT_UNPACK_CNT_EN
    logic consume;

    // Only a consume while a field is presented counts; the add wraps naturally at 16 bits.
    assign consume = (state == HOLD) && rinc_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_cnt <= '0;
        end else if (consume) begin
            field_cnt <= field_cnt + 16'd1;
        end
    end
`else
    // No consumed-field counter in this build.
`endif

endmodule

// File: tb/tb_bit_unpack.sv
// Directed bench for bit_unpack: a FIELD_W=4 and a FIELD_W=8 instance share clock and reset.
module tb_bit_unpack;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enb4, bit4, rempty_in4, rinc_in4, rinc_out4, rempty_out4;
    logic [3:0] field4;
    logic       enb8, bit8, rempty_in8, rinc_in8, rinc_out8, rempty_out8;
    logic [7:0] field8;
`ifdef BIT_UNPACK_CNT_EN
    logic [15:0] fc4, fc8;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bit_unpack #(.FIELD_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .enb(enb4), .bit_val(bit4), .rempty_in(rempty_in4),
        .rinc_out(rinc_out4), .field(field4), .rempty_out(rempty_out4), .rinc_in(rinc_in4)
`ifdef BIT_UNPACK_CNT_EN
        , .field_cnt(fc4)
`endif
    );

    bit_unpack #(.FIELD_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .enb(enb8), .bit_val(bit8), .rempty_in(rempty_in8),
        .rinc_out(rinc_out8), .field(field8), .rempty_out(rempty_out8), .rinc_in(rinc_in8)
`ifdef BIT_UNPACK_CNT_EN
        , .field_cnt(fc8)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        enb4 = 0; bit4 = 0; rempty_in4 = 0; rinc_in4 = 0;
        enb8 = 0; bit8 = 0; rempty_in8 = 0; rinc_in8 = 0;
        #2;
        n_vec++; if (rinc_out4 !== 1'b0) begin n_err++; $display("FAIL reset_rinc_out4: got %b want 0", rinc_out4); end
        n_vec++; if (rempty_out4 !== 1'b1) begin n_err++; $display("FAIL reset_rempty_out4: got %b want 1", rempty_out4); end
        n_vec++; if (field4 !== 4'h0) begin n_err++; $display("FAIL reset_field4: got %h want 0", field4); end
        n_vec++; if (rinc_out8 !== 1'b0) begin n_err++; $display("FAIL reset_rinc_out8: got %b want 0", rinc_out8); end
        n_vec++; if (rempty_out8 !== 1'b1) begin n_err++; $display("FAIL reset_rempty_out8: got %b want 1", rempty_out8); end
        n_vec++; if (field8 !== 8'h00) begin n_err++; $display("FAIL reset_field8: got %h want 00", field8); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick;
        n_vec++; if (rinc_out4 !== 1'b0 || rempty_out4 !== 1'b1) begin n_err++; $display("FAIL idle_after_reset4: rinc_out=%b rempty_out=%b want 0/1", rinc_out4, rempty_out4); end
        n_vec++; if (rinc_out8 !== 1'b0 || rempty_out8 !== 1'b1) begin n_err++; $display("FAIL idle_after_reset8: rinc_out=%b rempty_out=%b want 0/1", rinc_out8, rempty_out8); end
    endtask

    task automatic test_basic4;
        logic [3:0] v;
        v = 4'hD;
        enb4 = 1; rempty_in4 = 0;
        #1;
        n_vec++; if (rinc_out4 !== 1'b0) begin n_err++; $display("FAIL basic_idle_pop: got %b want 0", rinc_out4); end
        tick;
        for (int i = 0; i < 4; i++) begin
            bit4 = v[i];
            #1;
            n_vec++; if (rinc_out4 !== 1'b1) begin n_err++; $display("FAIL basic_pop%0d: got %b want 1", i, rinc_out4); end
            n_vec++; if (rempty_out4 !== 1'b1) begin n_err++; $display("FAIL basic_empty%0d: got %b want 1", i, rempty_out4); end
            tick;
        end
        n_vec++; if (rempty_out4 !== 1'b0) begin n_err++; $display("FAIL basic_present: rempty_out=%b want 0", rempty_out4); end
        n_vec++; if (field4 !== 4'hD) begin n_err++; $display("FAIL basic_field: got %h want d", field4); end
        n_vec++; if (rinc_out4 !== 1'b0) begin n_err++; $display("FAIL basic_hold_pop: got %b want 0", rinc_out4); end
        enb4 = 0; rinc_in4 = 1;
        tick;
        rinc_in4 = 0;
        #1;
        n_vec++; if (rempty_out4 !== 1'b1 || rinc_out4 !== 1'b0) begin n_err++; $display("FAIL basic_consumed: rempty_out=%b rinc_out=%b want 1/0", rempty_out4, rinc_out4); end
    endtask

    task automatic test_stall4;
        logic [3:0] v;
        v = 4'h6;
        enb4 = 1; rempty_in4 = 0;
        tick;
        for (int i = 0; i < 2; i++) begin
            bit4 = v[i];
            tick;
        end
        rempty_in4 = 1; bit4 = 0; rinc_in4 = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if (rinc_out4 !== 1'b0) begin n_err++; $display("FAIL stall_pop%0d: got %b want 0", c, rinc_out4); end
            n_vec++; if (u4.cnt !== 5'd2) begin n_err++; $display("FAIL stall_cnt%0d: got %0d want 2", c, u4.cnt); end
            n_vec++; if (rempty_out4 !== 1'b1) begin n_err++; $display("FAIL stall_empty%0d: got %b want 1", c, rempty_out4); end
            tick;
        end
        rinc_in4 = 0; rempty_in4 = 0;
        for (int i = 2; i < 4; i++) begin
            bit4 = v[i];
            #1;
            n_vec++; if (rinc_out4 !== 1'b1) begin n_err++; $display("FAIL stall_resume%0d: got %b want 1", i, rinc_out4); end
            tick;
        end
        n_vec++; if (field4 !== 4'h6 || rempty_out4 !== 1'b0) begin n_err++; $display("FAIL stall_field: field=%h rempty_out=%b want 6/0", field4, rempty_out4); end
        enb4 = 0; rinc_in4 = 1;
        tick;
        rinc_in4 = 0;
    endtask

    task automatic test_back_to_back;
        logic [3:0] vals [2];
        logic [3:0] v;
        vals[0] = 4'h9;
        vals[1] = 4'h6;
        enb4 = 1; rempty_in4 = 0;
        tick;
        for (int f = 0; f < 2; f++) begin
            v = vals[f];
            for (int i = 0; i < 4; i++) begin
                bit4 = v[i];
                #1;
                n_vec++; if (rinc_out4 !== 1'b1) begin n_err++; $display("FAIL b2b_pop%0d_%0d: got %b want 1", f, i, rinc_out4); end
                tick;
            end
            #1;
            n_vec++; if (field4 !== v) begin n_err++; $display("FAIL b2b_field%0d: got %h want %h", f, field4, v); end
            n_vec++; if (rinc_out4 !== 1'b0) begin n_err++; $display("FAIL b2b_bubble%0d: got %b want 0", f, rinc_out4); end
            enb4 = (f == 0); rinc_in4 = 1;
            tick;
            rinc_in4 = 0;
        end
        #1;
        n_vec++; if (rempty_out4 !== 1'b1 || rinc_out4 !== 1'b0) begin n_err++; $display("FAIL b2b_idle: rempty_out=%b rinc_out=%b want 1/0", rempty_out4, rinc_out4); end
    endtask

    task automatic test_hold8;
        logic [7:0] v;
        v = 8'hA5;
        enb8 = 1; rempty_in8 = 0;
        tick;
        for (int i = 0; i < 8; i++) begin
            bit8 = v[i];
            #1;
            n_vec++; if (rinc_out8 !== 1'b1) begin n_err++; $display("FAIL hold_fill_pop%0d: got %b want 1", i, rinc_out8); end
            tick;
        end
        rinc_in8 = 0;
        for (int c = 0; c < 10; c++) begin
            bit8 = ~bit8;
            #1;
            n_vec++; if (field8 !== 8'hA5 || rempty_out8 !== 1'b0 || rinc_out8 !== 1'b0) begin
                n_err++; $display("FAIL hold_cycle%0d: field=%h rempty_out=%b rinc_out=%b want a5/0/0", c, field8, rempty_out8, rinc_out8);
            end
            tick;
        end
        enb8 = 0; rinc_in8 = 1;
        tick;
        rinc_in8 = 0;
        #1;
        n_vec++; if (rempty_out8 !== 1'b1) begin n_err++; $display("FAIL hold_release: rempty_out=%b want 1", rempty_out8); end
    endtask

    task automatic test_enb_drop8;
        logic [7:0] v;
        v = 8'h3C;
        enb8 = 1; rempty_in8 = 0;
        tick;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) enb8 = 0;
            bit8 = v[i];
            #1;
            n_vec++; if (rinc_out8 !== 1'b1) begin n_err++; $display("FAIL drop_pop%0d: got %b want 1", i, rinc_out8); end
            tick;
        end
        n_vec++; if (field8 !== 8'h3C || rempty_out8 !== 1'b0) begin n_err++; $display("FAIL drop_field: field=%h rempty_out=%b want 3c/0", field8, rempty_out8); end
        rinc_in8 = 1;
        tick;
        rinc_in8 = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++; if (rinc_out8 !== 1'b0 || rempty_out8 !== 1'b1) begin n_err++; $display("FAIL drop_idle%0d: rinc_out=%b rempty_out=%b want 0/1", c, rinc_out8, rempty_out8); end
            tick;
        end
    endtask

    task automatic test_reset_mid8;
        logic [7:0] v;
        enb8 = 1; rempty_in8 = 0; bit8 = 1;
        tick;
        for (int i = 0; i < 5; i++) tick;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (rinc_out8 !== 1'b0 || rempty_out8 !== 1'b1) begin n_err++; $display("FAIL rstmid_ctrl: rinc_out=%b rempty_out=%b want 0/1", rinc_out8, rempty_out8); end
        n_vec++; if (field8 !== 8'h00 || u8.cnt !== 5'd0) begin n_err++; $display("FAIL rstmid_data: field=%h cnt=%0d want 00/0", field8, u8.cnt); end
        tick;
        n_vec++; if (rinc_out8 !== 1'b0) begin n_err++; $display("FAIL rstmid_nopop: got %b want 0", rinc_out8); end
        rst_n = 1'b1; enb8 = 0;
        tick;
        n_vec++; if (rinc_out8 !== 1'b0 || rempty_out8 !== 1'b1) begin n_err++; $display("FAIL rstmid_idle: rinc_out=%b rempty_out=%b want 0/1", rinc_out8, rempty_out8); end
        v = 8'h12;
        enb8 = 1;
        tick;
        for (int i = 0; i < 8; i++) begin
            bit8 = v[i];
            tick;
        end
        n_vec++; if (field8 !== 8'h12 || rempty_out8 !== 1'b0) begin n_err++; $display("FAIL rstmid_clean: field=%h rempty_out=%b want 12/0", field8, rempty_out8); end
        enb8 = 0; rinc_in8 = 1;
        tick;
        rinc_in8 = 0;
    endtask

`ifdef BIT_UNPACK_CNT_EN
    task automatic test_field_cnt;
        rst_n = 1'b0;
        #1;
        n_vec++; if (fc4 !== 16'd0) begin n_err++; $display("FAIL cnt_reset: got %0d want 0", fc4); end
        tick;
        rst_n = 1'b1; rempty_in4 = 0;
        for (int f = 0; f < 3; f++) begin
            enb4 = 1;
            tick;
            rinc_in4 = 1;
            for (int i = 0; i < 4; i++) tick;
            enb4 = 0;
            tick;
            rinc_in4 = 0;
        end
        n_vec++; if (fc4 !== 16'd3) begin n_err++; $display("FAIL cnt_three: got %0d want 3", fc4); end
        rinc_in4 = 1;
        repeat (2) tick;
        rinc_in4 = 0;
        n_vec++; if (fc4 !== 16'd3) begin n_err++; $display("FAIL cnt_ignored: got %0d want 3", fc4); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic4;
        test_stall4;
        test_back_to_back;
        test_hold8;
        test_enb_drop8;
        test_reset_mid8;
`ifdef BIT_UNPACK_CNT_EN
        test_field_cnt;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
